present_stream_frontend: RTL and testbench
==========================================

Name: present_stream_frontend

Overview:
Byte-serial front end for the PRESENT-80 encrypt core.
- Assembles an 80-bit key and a 64-bit plaintext block from a valid/ready byte stream.
- Restarts the core for each block, runs it to completion with a timeout, captures the ciphertext, and streams it out as bytes.
- Sits directly upstream and downstream of the encrypt core; it is the only block that drives the core's key, plaintext, enable and reset.

Parameters:
TIMEOUT, 40, max RUN cycles to wait for core_done before aborting (core nominally needs 31).

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid && in_ready
in_data  in  8  input byte, MSB-first within key and block
load_key  in  1  sampled on first byte of a frame: 1 = 18-byte frame (10 key + 8 pt), 0 = 8-byte frame reusing stored key
out_valid  out  1  ciphertext byte valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  8  ciphertext byte, MSB first
out_last  out  1  high with 8th ciphertext byte
core_key  out  80  key to core (stored key register)
core_plaintext  out  64  plaintext to core
core_rst_n  out  1  active-low restart to core
core_enable  out  1  run enable to core
core_done  in  1  core finished
core_ciphertext  in  64  core result, valid while core_done
busy  out  1  state != IDLE
key_valid  out  1  a key has been loaded since Reset
err_timeout  out  1  sticky, set on timeout, cleared only by Reset

Behaviour:
- Reset (sync, high): state=IDLE; key, pt, ct regs = 0; byte counter = 0; run counter = 0; core_rst_n=1, core_enable=0, out_valid=0, out_last=0, key_valid=0, err_timeout=0. in_ready is 0 in any cycle where Reset is high.
- in_ready=1 in IDLE, KEY, PT; 0 otherwise. out_valid=1 only in DRAIN.
- IDLE: on the first accepted byte, sample load_key.
  - load_key=1: byte goes to key[79:72], byte count=1, go to KEY.
  - load_key=0: byte goes to pt[63:56], byte count=1, go to PT. Stored key is reused; if key_valid=0 the key is all-zero.
- KEY: each accepted byte fills the next lower key byte. On the 10th key byte, set key_valid=1, reset byte count, go to PT.
- PT: each accepted byte fills the next lower pt byte. On the 8th byte, go to PRIME.
- load_key is ignored after the first byte of a frame.
- PRIME, exactly 1 cycle: core_rst_n=0, core_enable=0, so the core reloads key and plaintext. Go to RUN.
- RUN: core_rst_n=1, core_enable=1; run counter increments each cycle.
  - core_done=1: capture core_ciphertext into ct register the same edge, core_enable=0 next cycle, go to DRAIN.
  - Run counter reaches TIMEOUT without done: set err_timeout, core_enable=0, go to IDLE; no output is produced. Done on the TIMEOUT cycle itself counts as success.
- DRAIN:
  - out_data = ct byte [63-8i -: 8] for i = 0..7.
  - out_data and out_last stay stable while out_ready=0.
  - On the i=7 handshake, go to IDLE; in_ready is 1 on the following cycle.
- Latency, 8-byte frame, no stalls: last pt byte accepted at cycle t; PRIME t+1; RUN from t+2; first out_valid one cycle after core_done is sampled.
- core_key and core_plaintext are driven continuously from their registers. core_plaintext is stable from PRIME through end of RUN.
- Reset during any state aborts the job: partial input discarded, stored key cleared, no output.
- core_done seen outside RUN is ignored.

Decomposition:
- Shared package: KEY_W=80, BLK_W=64, BYTE_W=8, KEY_BYTES=10, BLK_BYTES=8, state enum {IDLE, KEY, PT, PRIME, RUN, DRAIN}.
- Natural sub-module: present_ct_serializer (64-bit load, byte-serial valid/ready drain, out_last generation).

Test Plan:
1. Frame load_key=1, key=0x00000000000000000000, pt=0x0000000000000000, no stalls -> bytes 55 79 C1 38 7B 22 84 45, out_last on 0x45, key_valid=1.
2. Then frame load_key=0, pt=0xFFFFFFFFFFFFFFFF (stored zero key reused) -> A112FFC72F68417B. Then load_key=1, key=all-FF, pt=all-FF -> 3333DCD3213210D2.
3. Backpressure: case 1 with out_ready toggled 0/1 every cycle and in_valid gaps -> identical bytes; out_data held while out_ready=0; in_ready=0 during PRIME, RUN, DRAIN.
4. Timeout: core_done tied 0 -> after PRIME, core_enable=1 for exactly 40 cycles; err_timeout=1; busy=0; out_valid never asserted; next frame still accepted with in_ready=1.
5. Reset mid-job: assert Reset for 1 cycle during KEY (byte 5) and again during DRAIN (byte 3) -> all outputs at reset values next cycle; key_valid=0; next load_key=0 frame pt=0 encrypts with zero key -> 5579C1387B228445.

Source files
------------

// File: rtl/present_stream_frontend_pkg.sv
// Shared widths and FSM encoding for the PRESENT-80 byte-stream front end.
package present_stream_frontend_pkg;

    localparam int KEY_W     = 80;
    localparam int BLK_W     = 64;
    localparam int BYTE_W    = 8;
    localparam int KEY_BYTES = 10;
    localparam int BLK_BYTES = 8;
    localparam int CNT_W     = 4;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        PT,
        PRIME,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/present_stream_frontend_ct_serializer.sv
// Holds one captured ciphertext block and hands it downstream MSB byte first.
module present_ct_serializer
    import present_stream_frontend_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              drained
);

    logic [BLK_W-1:0] ct_q, ct_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_byte;

    assign last_byte = (idx_q == IDX_W'(BLK_BYTES - 1));
    assign out_valid = valid_q;
    assign out_last  = valid_q && last_byte;
    assign drained   = valid_q && out_ready && last_byte;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) out_data = ct_q[BLK_W-1-BYTE_W*i -: BYTE_W];
        end
    end

    always_comb begin
        ct_d    = ct_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            ct_d    = load_data;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            idx_d = last_byte ? '0 : idx_q + 1'b1;
            if (last_byte) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ct_q    <= ct_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/present_stream_frontend.sv
// Assembles key/plaintext from a byte stream, sequences the PRESENT core and
// streams the ciphertext back out.
module present_stream_frontend
    import present_stream_frontend_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              load_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic [KEY_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_plaintext,
    output logic              core_rst_n,
    output logic              core_enable,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  core_ciphertext,
    output logic              busy,
    output logic              key_valid,
    output logic              err_timeout
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    // Both byte ports transfer on a cycle where valid && ready are high at the
    // rising edge; valid never waits on ready, and out_data holds until taken.
    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [BLK_W-1:0]  pt_q, pt_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              core_enable_q, core_enable_d;
    logic              key_valid_q, key_valid_d;
    logic              err_timeout_q, err_timeout_d;
    logic              accept, ct_load, drained;

    assign in_ready       = !Reset && (state_q == IDLE || state_q == KEY || state_q == PT);
    assign accept         = in_valid && in_ready;
    assign busy           = (state_q != IDLE);
    assign core_key       = key_q;
    assign core_plaintext = pt_q;
    assign core_rst_n     = core_rst_n_q;
    assign core_enable    = core_enable_q;
    assign key_valid      = key_valid_q;
    assign err_timeout    = err_timeout_q;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        pt_d          = pt_q;
        byte_cnt_d    = byte_cnt_q;
        run_cnt_d     = run_cnt_q;
        core_rst_n_d  = 1'b1;
        core_enable_d = core_enable_q;
        key_valid_d   = key_valid_q;
        err_timeout_d = err_timeout_q;
        ct_load       = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                byte_cnt_d = CNT_W'(1);
                if (load_key) begin
                    key_d[KEY_W-1 -: BYTE_W] = in_data;
                    state_d = KEY;
                end else begin
                    pt_d[BLK_W-1 -: BYTE_W] = in_data;
                    state_d = PT;
                end
            end
            KEY: if (accept) begin
                for (int i = 0; i < KEY_BYTES; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) key_d[KEY_W-1-BYTE_W*i -: BYTE_W] = in_data;
                end
                if (byte_cnt_q == CNT_W'(KEY_BYTES - 1)) begin
                    byte_cnt_d  = '0;
                    key_valid_d = 1'b1;
                    state_d     = PT;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            PT: if (accept) begin
                for (int i = 0; i < BLK_BYTES; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) pt_d[BLK_W-1-BYTE_W*i -: BYTE_W] = in_data;
                end
                if (byte_cnt_q == CNT_W'(BLK_BYTES - 1)) begin
                    byte_cnt_d   = '0;
                    core_rst_n_d = 1'b0;
                    state_d      = PRIME;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            PRIME: begin
                core_enable_d = 1'b1;
                run_cnt_d     = '0;
                state_d       = RUN;
            end
            RUN: begin
                // A done on the final allowed cycle still wins over the timeout.
                if (core_done) begin
                    ct_load       = 1'b1;
                    core_enable_d = 1'b0;
                    state_d       = DRAIN;
                end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    core_enable_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            DRAIN: if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            key_q         <= '0;
            pt_q          <= '0;
            byte_cnt_q    <= '0;
            run_cnt_q     <= '0;
            core_rst_n_q  <= 1'b1;
            core_enable_q <= 1'b0;
            key_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            pt_q          <= pt_d;
            byte_cnt_q    <= byte_cnt_d;
            run_cnt_q     <= run_cnt_d;
            core_rst_n_q  <= core_rst_n_d;
            core_enable_q <= core_enable_d;
            key_valid_q   <= key_valid_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    present_ct_serializer u_ser (
        .clk       (Clock),
        .rst       (Reset),
        .load      (ct_load),
        .load_data (core_ciphertext),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .drained   (drained)
    );

endmodule

// File: tb/tb_present_stream_frontend.sv
// Directed bench for present_stream_frontend with a behavioural PRESENT-80 core.
module tb_present_stream_frontend;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        load_key = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic [79:0] core_key;
    logic [63:0] core_plaintext;
    logic        core_rst_n;
    logic        core_enable;
    logic        core_done;
    logic [63:0] core_ciphertext;
    logic        busy;
    logic        key_valid;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 Clock = ~Clock;

    present_stream_frontend #(.TIMEOUT(40)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .load_key        (load_key),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_rst_n      (core_rst_n),
        .core_enable     (core_enable),
        .core_done       (core_done),
        .core_ciphertext (core_ciphertext),
        .busy            (busy),
        .key_valid       (key_valid),
        .err_timeout     (err_timeout)
    );

    // Behavioural core: loads on core_rst_n low, done after 31 enabled cycles.
    function automatic logic [63:0] present_enc(input logic [79:0] k_in, input logic [63:0] p);
        logic [79:0] k;
        logic [63:0] s, t;
        logic [3:0]  sbox [16];
        sbox = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        k = k_in;
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox[s[4*n +: 4]];
            t = '0;
            for (int b = 0; b < 63; b++) t[(16*b) % 63] = s[b];
            t[63] = s[63];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    logic [63:0] m_ct = '0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    bit          m_hang = 1'b0;

    always @(posedge Clock) begin
        if (!core_rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_ct   <= present_enc(core_key, core_plaintext);
        end else if (core_enable && !m_done && !m_hang) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 30) m_done <= 1'b1;
        end
    end

    assign core_done       = m_done;
    assign core_ciphertext = m_done ? m_ct : 64'h0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lk, input int gap);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        load_key = lk;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 80'(in_ready), 80'(1));
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    // Drives load_key inverted after the first byte, since it must be ignored there.
    task automatic send_frame(input bit lk, input logic [79:0] key, input logic [63:0] pt, input int gap);
        int j = 0;
        if (lk) begin
            for (int i = 0; i < 10; i++) begin
                send_byte(key[79-8*i -: 8], (j == 0) ? lk : !lk, gap);
                j++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(pt[63-8*i -: 8], (j == 0) ? lk : !lk, (i == 7) ? 0 : gap);
            j++;
        end
    endtask

    task automatic collect(input logic [63:0] ct, input bit toggle, input int n, output int lat);
        int cyc = 0;
        int got = 0;
        bit hold_v = 1'b0;
        logic [7:0] hold_d = '0;
        logic hold_l = 1'b0;
        logic [7:0] e;
        lat = -1;
        for (int i = 0; i < n; i++) exp_q.push_back(ct[63-8*i -: 8]);
        while (got < n && cyc < 400) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            check("in_ready_busy", 80'(in_ready), 80'(0));
            if (hold_v && out_valid) begin
                check("hold_data", 80'(out_data), 80'(hold_d));
                check("hold_last", 80'(out_last), 80'(hold_l));
            end
            hold_v = 1'b0;
            if (out_valid && lat < 0) begin
                lat = cyc;
                check("enable_off_drain", 80'(core_enable), 80'(0));
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_data", 80'(out_data), 80'(e));
                check("out_last", 80'(out_last), 80'(got == 7));
                got++;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
                hold_l = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (got < n) begin
            check("drain_budget", 80'(got), 80'(n));
            exp_q.delete();
        end
    endtask

    task automatic check_prime(input logic [79:0] key, input logic [63:0] pt);
        check("prime_rst_n", 80'(core_rst_n), 80'(0));
        check("prime_enable", 80'(core_enable), 80'(0));
        check("prime_in_ready", 80'(in_ready), 80'(0));
        check("prime_key", core_key, key);
        check("prime_pt", 80'(core_plaintext), 80'(pt));
    endtask

    task automatic check_idle_after();
        check("idle_busy", 80'(busy), 80'(0));
        check("idle_in_ready", 80'(in_ready), 80'(1));
        check("idle_out_valid", 80'(out_valid), 80'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 80'(busy), 80'(0));
        check({tag, "_key_valid"}, 80'(key_valid), 80'(0));
        check({tag, "_err"}, 80'(err_timeout), 80'(0));
        check({tag, "_out_valid"}, 80'(out_valid), 80'(0));
        check({tag, "_out_last"}, 80'(out_last), 80'(0));
        check({tag, "_rst_n"}, 80'(core_rst_n), 80'(1));
        check({tag, "_enable"}, 80'(core_enable), 80'(0));
        check({tag, "_key"}, core_key, 80'(0));
        check({tag, "_pt"}, 80'(core_plaintext), 80'(0));
        check({tag, "_in_ready"}, 80'(in_ready), 80'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int en_cnt;
        bit saw_valid;
        int guard;

        // Reset
        Reset = 1'b1;
        tick();
        check("rst_in_ready", 80'(in_ready), 80'(0));
        tick();
        Reset = 1'b0;
        #1;
        check_reset_state("rst");

        // 1: zero key, zero plaintext, no stalls
        send_frame(1'b1, 80'h0, 64'h0, 0);
        check_prime(80'h0, 64'h0);
        collect(64'h5579C1387B228445, 1'b0, 8, lat);
        check("latency", 80'(lat), 80'(33));
        check_idle_after();
        check("key_valid_t1", 80'(key_valid), 80'(1));

        // 2: stored zero key reused, then all-FF key and block
        send_frame(1'b0, 80'h0, 64'hFFFFFFFFFFFFFFFF, 0);
        check_prime(80'h0, 64'hFFFFFFFFFFFFFFFF);
        collect(64'hA112FFC72F68417B, 1'b0, 8, lat);
        check_idle_after();
        send_frame(1'b1, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF, 0);
        check_prime({80{1'b1}}, 64'hFFFFFFFFFFFFFFFF);
        collect(64'h3333DCD3213210D2, 1'b0, 8, lat);
        check_idle_after();

        // 3: input gaps and output backpressure
        send_frame(1'b1, 80'h0, 64'h0, 2);
        check_prime(80'h0, 64'h0);
        collect(64'h5579C1387B228445, 1'b1, 8, lat);
        check_idle_after();

        // 4: core never finishes
        m_hang = 1'b1;
        send_frame(1'b0, 80'h0, 64'h0123456789ABCDEF, 0);
        check_prime(80'h0, 64'h0123456789ABCDEF);
        en_cnt = 0;
        saw_valid = 1'b0;
        guard = 0;
        out_ready = 1'b1;
        while (busy && guard < 200) begin
            if (core_enable) en_cnt++;
            if (out_valid) saw_valid = 1'b1;
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("to_enable_cycles", 80'(en_cnt), 80'(40));
        check("to_err", 80'(err_timeout), 80'(1));
        check("to_busy", 80'(busy), 80'(0));
        check("to_no_output", 80'(saw_valid), 80'(0));
        check("to_enable_off", 80'(core_enable), 80'(0));
        check("to_in_ready", 80'(in_ready), 80'(1));
        m_hang = 1'b0;
        send_frame(1'b0, 80'h0, 64'h0, 0);
        collect(64'h5579C1387B228445, 1'b0, 8, lat);
        check("to_err_sticky", 80'(err_timeout), 80'(1));

        // 5: reset during KEY (after 5 key bytes), then during DRAIN (after 3 bytes)
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), (i == 0), 0);
        check("mid_key_busy", 80'(busy), 80'(1));
        Reset = 1'b1;
        #1;
        check("mid_key_in_ready", 80'(in_ready), 80'(0));
        tick();
        Reset = 1'b0;
        #1;
        check_reset_state("rst_key");

        send_frame(1'b1, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF, 0);
        collect(64'h3333DCD3213210D2, 1'b0, 3, lat);
        check("mid_drain_valid", 80'(out_valid), 80'(1));
        Reset = 1'b1;
        #1;
        check("mid_drain_in_ready", 80'(in_ready), 80'(0));
        tick();
        Reset = 1'b0;
        #1;
        check_reset_state("rst_drain");

        send_frame(1'b0, 80'h0, 64'h0, 0);
        check_prime(80'h0, 64'h0);
        collect(64'h5579C1387B228445, 1'b0, 8, lat);
        check_idle_after();
        check("final_key_valid", 80'(key_valid), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
